// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register width, forward-select encoding and the
// in-flight write scoreboard entry used by the forwarding/hazard logic.
package cpu_pkg;

  localparam int REG_W = 3;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             load;
  } sb_entry_t;

endpackage

// File: rtl/fwd_match_prio.sv
// Per-operand priority matcher: finds the youngest valid scoreboard stage whose
// destination equals the operand's source register.
module fwd_match_prio
  import cpu_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int SEL_W = $clog2(DEPTH + 1)
) (
  input  logic                  used,
  input  logic [REG_W-1:0]      rs,
  input  sb_entry_t [DEPTH:1]   sb,
  output logic                  hit,
  output logic [SEL_W-1:0]      sel,
  output logic                  is_load
);

  // Walk oldest to youngest so the youngest match overwrites older ones.
  // The valid term gates the compare, so unknown rd on empty stages is masked.
  always_comb begin
    hit     = 1'b0;
    sel     = '0;
    is_load = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (used && sb[k].valid && (sb[k].rd == rs)) begin
        hit     = 1'b1;
        sel     = SEL_W'(k);
        is_load = sb[k].load;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: scoreboard of in-flight register writes,
// per-operand forward select, decode stall and saturating stall counter.
module fwd_hazard_unit #(
  parameter  int REG_W      = cpu_pkg::REG_W,
  parameter  int DEPTH      = 3,
  parameter  int NUM_SRC    = 2,
  parameter  int LOAD_READY = 2,
  localparam int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_flush,
  input  logic                     i_hold,
  input  logic                     i_issue_valid,
  input  logic                     i_issue_we,
  input  logic                     i_issue_load,
  input  logic [REG_W-1:0]         i_issue_rd,
  input  logic [NUM_SRC*REG_W-1:0] i_rs,
  input  logic [NUM_SRC-1:0]       i_rs_used,
  output logic [NUM_SRC*SEL_W-1:0] o_fwd_sel,
  output logic                     o_stall,
  output logic [15:0]              o_stall_cnt
);
  import cpu_pkg::*;

  // The entry struct is sized by the package, so the two widths must agree.
  if (REG_W != cpu_pkg::REG_W) begin : g_bad_reg_w
    $error("fwd_hazard_unit: REG_W must equal cpu_pkg::REG_W");
  end
  if (LOAD_READY < 2 || LOAD_READY > DEPTH) begin : g_bad_load_ready
    $error("fwd_hazard_unit: LOAD_READY must be in 2..DEPTH");
  end

  localparam logic [SEL_W-1:0] LR_SEL = SEL_W'(LOAD_READY);

  sb_entry_t [DEPTH:1]             sb_q;
  logic [NUM_SRC-1:0]              hit;
  logic [NUM_SRC-1:0]              is_load;
  logic [NUM_SRC-1:0][SEL_W-1:0]   sel;
  logic [NUM_SRC-1:0]              lane_stall;
  logic                            issue_wr;

  for (genvar j = 0; j < NUM_SRC; j++) begin : g_src
    fwd_match_prio #(
      .DEPTH (DEPTH),
      .SEL_W (SEL_W)
    ) u_match (
      .used    (i_rs_used[j]),
      .rs      (i_rs[j*REG_W +: REG_W]),
      .sb      (sb_q),
      .hit     (hit[j]),
      .sel     (sel[j]),
      .is_load (is_load[j])
    );

    // Load data not yet available at the youngest producer stage.
    assign lane_stall[j] = hit[j] & is_load[j] & (sel[j] < LR_SEL);
    assign o_fwd_sel[j*SEL_W +: SEL_W] = sel[j];
  end

  assign o_stall  = i_issue_valid & ~i_flush & (|lane_stall);
  assign issue_wr = i_issue_valid & i_issue_we & ~o_stall;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sb_q <= '0;
    end else if (i_flush) begin
      for (int k = 1; k <= DEPTH; k++) sb_q[k].valid <= 1'b0;
    end else if (!i_hold) begin
      for (int k = DEPTH; k >= 2; k--) sb_q[k] <= sb_q[k-1];
      // A stalled instruction re-presents next cycle, so it enters as a bubble now.
      sb_q[1].valid <= issue_wr;
      sb_q[1].rd    <= i_issue_rd;
      sb_q[1].load  <= i_issue_load;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stall_cnt <= '0;
    end else if (o_stall && !i_hold && (o_stall_cnt != 16'hFFFF)) begin
      o_stall_cnt <= o_stall_cnt + 16'd1;
    end
  end

endmodule
